bumpy_round_ctrl: RTL
=====================

# bumpy_round_ctrl

Round/turn controller for the Bumpy game; it sequences the smiley movement datapath through spawn, play, death and win phases. It gates the raw keyboard move requests into at most one move command per frame and issues the `endGame` respawn pulse that makes the movement block reload a random start tile. It also keeps the lives count and exposes the game phase to the HUD/drawing logic. It sits between the keyboard decoder, the collision/goal detectors and the smiley movement block.

## Interface
Parameters:
- `LIVES`, 3: lives loaded on new game; range 1..7.
- `SPAWN_FRAMES`, 30: frames of frozen input after each spawn; range 1..255.
- `DEATH_FRAMES`, 45: frames in DYING before respawn or game over; range 1..255.
- `WIN_FRAMES`, 90: frames in WIN before returning to IDLE; range 1..255.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: reset, **synchronous, active-high**.
- `startOfFrame` in 1: one-cycle pulse per video frame.
- `startKeyN` in 1: start key, active low, level.
- `rightN`, `leftN`, `jumpN` in 1 each: raw move keys, active low, level.
- `deathHit` in 1: smiley touched a hazard (level, any cycle).
- `goalHit` in 1: smiley touched the goal tile (level, any cycle).
- `moveRightN`, `moveLeftN`, `moveJumpN` out 1 each: gated move commands to the movement block, active low.
- `endGame` out 1: one-cycle respawn pulse to the movement block.
- `livesLeft` out 3: remaining lives.
- `gameState` out 3: IDLE=0, SPAWN=1, PLAY=2, DYING=3, WIN=4, OVER=5.

## Operation
- **Start key:** a registered copy of `startKeyN` is kept. A start press means a falling edge: previous sample 1, current sample 0.
- **Frame counter:** 8-bit `frameCnt`.
  - Cleared on every state entry.
  - Increments only on `startOfFrame`.
  - A timed state exits on the `startOfFrame` where `frameCnt == N-1`, so the state lasts exactly N frame pulses.
- **IDLE:** on a start press, `livesLeft` <= `LIVES`, pulse `endGame`, go to SPAWN.
- **SPAWN:** all move outputs are held at 1. After `SPAWN_FRAMES`, go to PLAY.
- **PLAY:**
  - `goalHit` -> WIN. If `goalHit` and `deathHit` arrive in the same cycle, `goalHit` wins.
  - Otherwise `deathHit` -> DYING, and `livesLeft` is decremented on that transition. It saturates at 0.
- **DYING:** move outputs held at 1. After `DEATH_FRAMES`:
  - `livesLeft == 0` -> OVER.
  - Otherwise pulse `endGame` and go to SPAWN.
- **WIN:** after `WIN_FRAMES`, go to IDLE. `livesLeft` is retained.
- **OVER:** on a start press, reload `livesLeft`, pulse `endGame`, go to SPAWN.
- **Move arbitration (PLAY only):**
  - On each `startOfFrame`, sample `jumpN`, `rightN` and `leftN`.
  - Priority is jump > right > left.
  - Drive exactly the selected output low and hold it until the next `startOfFrame`. If no key is pressed, all outputs stay 1.
- **Forcing outputs high:** all move outputs go to 1 in the cycle after leaving PLAY. They are 1 in every state other than PLAY.

## Timing
- **Reset values** (applied at the clock edge while `reset` = 1, takes priority over everything):
  - `gameState` = IDLE.
  - `livesLeft` = `LIVES`.
  - `moveRightN` = `moveLeftN` = `moveJumpN` = 1.
  - `endGame` = 0.
  - `frameCnt` = 0.
  - Start-key register = 1.
- **Reset mid-round:** identical result; no `endGame` pulse is issued.
- **Registered outputs:** all outputs are registered, and every decision appears one cycle after the qualifying input edge.
  - Start press sampled at cycle t -> `endGame` = 1 and `gameState` = SPAWN at t+1; `endGame` = 0 at t+2.
  - Key sampled on `startOfFrame` at t -> move output valid at t+1, held through the next `startOfFrame` cycle, updated at that cycle +1.
- **PLAY -> DYING/WIN:** taken in the cycle the hit is sampled. A hit arriving in the same cycle as `startOfFrame` still transitions, and no new move command is latched.
- **Exit from timed states:**
  - With N=1 the state exits on its first `startOfFrame`.
  - `frameCnt` never wraps, because exit happens at N-1 ≤ 254.
- **`endGame` pulse:** exactly one cycle wide per respawn. It never pulses in two consecutive cycles.
- **Ignored inputs:** `deathHit` and `goalHit` are ignored outside PLAY. A start press is ignored outside IDLE and OVER.

## Test plan
1. Reset, then `startKeyN` low at cycle 10 -> `endGame` high only in cycle 11; `gameState` = 1; `livesLeft` = 3.
2. Defaults, SPAWN entered -> `gameState` = 2 exactly on the cycle after the 30th `startOfFrame`. `jumpN` and `rightN` both held low during SPAWN give no move output.
3. PLAY with `jumpN` = `rightN` = `leftN` = 0 at a frame pulse -> only `moveJumpN` = 0 for the whole frame. Next frame with only `leftN` = 0 -> `moveLeftN` = 0, and `moveJumpN` = 1.
4. `deathHit` and `goalHit` asserted in the same cycle in PLAY -> `gameState` = 4 and `livesLeft` unchanged (3). After 90 frames, `gameState` = 0.
5. Three deaths with `LIVES` = 3 -> `livesLeft` goes 2, 1, 0. Two `endGame` pulses are seen, then `gameState` = 5 after the third DYING. A start press then gives `livesLeft` = 3, an `endGame` pulse, and SPAWN.
6. `reset` asserted mid-PLAY while `moveRightN` = 0 -> next cycle `moveRightN` = 1, `gameState` = 0, `livesLeft` = 3, `endGame` = 0.

Source files
------------

// File: rtl/bumpy_round_ctrl.sv
// rtl/bumpy_round_ctrl.sv - Bumpy round/turn controller: spawn, play, death and win sequencing
module bumpy_round_ctrl #(
  parameter int LIVES        = 3,
  parameter int SPAWN_FRAMES = 30,
  parameter int DEATH_FRAMES = 45,
  parameter int WIN_FRAMES   = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       startKeyN,
  input  logic       rightN,
  input  logic       leftN,
  input  logic       jumpN,
  input  logic       deathHit,
  input  logic       goalHit,
  output logic       moveRightN,
  output logic       moveLeftN,
  output logic       moveJumpN,
  output logic       endGame,
  output logic [2:0] livesLeft,
  output logic [2:0] gameState
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPAWN = 3'd1,
    ST_PLAY  = 3'd2,
    ST_DYING = 3'd3,
    ST_WIN   = 3'd4,
    ST_OVER  = 3'd5
  } state_t;

  // Last frame-counter value of each timed state; the state exits on the
  // frame pulse seen while the counter holds this value.
  localparam logic [7:0] SPAWN_LAST = 8'(SPAWN_FRAMES - 1);
  localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] WIN_LAST   = 8'(WIN_FRAMES - 1);
  localparam logic [2:0] LIVES_INIT = 3'(LIVES);

  state_t     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [2:0] lives_q, lives_d;
  logic       start_key_q, start_key_d;
  logic       end_game_q, end_game_d;
  logic       move_right_n_q, move_right_n_d;
  logic       move_left_n_q, move_left_n_d;
  logic       move_jump_n_q, move_jump_n_d;

  logic       start_press;
  logic       frame_last_spawn;
  logic       frame_last_death;
  logic       frame_last_win;

  // Start press is a falling edge of the start key against its registered copy.
  always_comb begin
    start_press      = start_key_q & ~startKeyN;
    start_key_d      = startKeyN;
    frame_last_spawn = startOfFrame && (frame_cnt_q == SPAWN_LAST);
    frame_last_death = startOfFrame && (frame_cnt_q == DEATH_LAST);
    frame_last_win   = startOfFrame && (frame_cnt_q == WIN_LAST);
  end

  // Phase sequencing, lives bookkeeping and the respawn pulse.
  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    end_game_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_press) begin
          lives_d    = LIVES_INIT;
          end_game_d = 1'b1;
          state_d    = ST_SPAWN;
        end
      end
      ST_SPAWN: begin
        if (frame_last_spawn) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // Goal takes precedence when both detectors fire together.
        if (goalHit) begin
          state_d = ST_WIN;
        end else if (deathHit) begin
          state_d = ST_DYING;
          lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
        end
      end
      ST_DYING: begin
        if (frame_last_death) begin
          if (lives_q == 3'd0) begin
            state_d = ST_OVER;
          end else begin
            end_game_d = 1'b1;
            state_d    = ST_SPAWN;
          end
        end
      end
      ST_WIN: begin
        if (frame_last_win) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frame counter restarts on every phase change and saturates in untimed phases.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_d != state_q) begin
      frame_cnt_d = 8'd0;
    end else if (startOfFrame && (frame_cnt_q != 8'hFF)) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  // One move command per frame while staying in PLAY; released everywhere else.
  always_comb begin
    move_right_n_d = 1'b1;
    move_left_n_d  = 1'b1;
    move_jump_n_d  = 1'b1;
    if ((state_q == ST_PLAY) && (state_d == ST_PLAY)) begin
      if (startOfFrame) begin
        if (!jumpN) begin
          move_jump_n_d = 1'b0;
        end else if (!rightN) begin
          move_right_n_d = 1'b0;
        end else if (!leftN) begin
          move_left_n_d = 1'b0;
        end
      end else begin
        move_right_n_d = move_right_n_q;
        move_left_n_d  = move_left_n_q;
        move_jump_n_d  = move_jump_n_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      frame_cnt_q    <= 8'd0;
      lives_q        <= LIVES_INIT;
      start_key_q    <= 1'b1;
      end_game_q     <= 1'b0;
      move_right_n_q <= 1'b1;
      move_left_n_q  <= 1'b1;
      move_jump_n_q  <= 1'b1;
    end else begin
      state_q        <= state_d;
      frame_cnt_q    <= frame_cnt_d;
      lives_q        <= lives_d;
      start_key_q    <= start_key_d;
      end_game_q     <= end_game_d;
      move_right_n_q <= move_right_n_d;
      move_left_n_q  <= move_left_n_d;
      move_jump_n_q  <= move_jump_n_d;
    end
  end

  assign moveRightN = move_right_n_q;
  assign moveLeftN  = move_left_n_q;
  assign moveJumpN  = move_jump_n_q;
  assign endGame    = end_game_q;
  assign livesLeft  = lives_q;
  assign gameState  = state_q;

endmodule
